// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word-aligned read at a time, buffers
// returned words with their PC, and hands them to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        buf_inst_q [BUF_DEPTH];
  logic [31:0]        buf_inst_d [BUF_DEPTH];
  logic [31:0]        buf_pc_q   [BUF_DEPTH];
  logic [31:0]        buf_pc_d   [BUF_DEPTH];
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        inst_pc_q, inst_pc_d;

  logic accept;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // The in-flight slot is counted against the buffer, so a response always has room.
  assign mem_req_valid = rst_n && (state_q == ST_REQ) && (count_q < DEPTH_C);
  assign mem_req_addr  = pc_q;
  assign inst_valid    = (count_q != '0);
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

  always_comb begin
    accept     = mem_req_valid && mem_req_ready;
    push       = (state_q == ST_WAIT) && mem_resp_valid && !redirect_valid;
    pop        = (count_q != '0) && inst_ready;

    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;

    case (state_q)
      ST_REQ: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) state_d = ST_REQ;
      end
      ST_DROP: begin
        if (mem_resp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase

    if (push) begin
      buf_inst_d[wr_ptr_q] = mem_resp_data;
      buf_pc_d[wr_ptr_q]   = req_pc_q;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;

    // A redirect flushes everything; a request already accepted still owes a response.
    if (redirect_valid) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (state_q == ST_REQ) state_d = accept ? ST_DROP : ST_REQ;
      else                   state_d = mem_resp_valid ? ST_REQ : ST_DROP;
    end

    // Head registers track the post-update buffer and hold their value when empty.
    if (count_d != '0) begin
      inst_d    = buf_inst_d[rd_ptr_d];
      inst_pc_d = buf_pc_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_inst_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule
